// File: rtl/muldiv_unit.sv
// RV M-extension iterative multiply/divide: radix-2 shift-add and restoring divide.
// Define MULDIV_FASTPATH_EN to retire zero/overflow/div-by-zero cases without iterating.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // {hit, value} for cases whose result does not come from the datapath
  function automatic logic [XLEN:0] special(
    input logic [2:0]      f,
    input logic [XLEN-1:0] x,
    input logic [XLEN-1:0] y
  );
    logic [XLEN-1:0] smin;
    logic [XLEN:0]   r;
    smin = '0;
    smin[XLEN-1] = 1'b1;
    r = '0;
    if (f[2]) begin
      if (y == '0)
        r = {1'b1, f[1] ? x : {XLEN{1'b1}}};
      else if (!f[0] && x == smin && y == {XLEN{1'b1}})
        r = {1'b1, f[1] ? {XLEN{1'b0}} : x};
    end else if (x == '0 || y == '0) begin
      r = {1'b1, {XLEN{1'b0}}};
    end
    return r;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   m_q, m_d;
  logic [2*XLEN-1:0] p_q, p_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   res_q, res_d;

  logic              accept;
  logic              sa_in, sb_in, neg_in;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [XLEN:0]     sum;
  logic [2*XLEN-1:0] mul_nx;
  logic [XLEN:0]     rs;
  logic [XLEN-1:0]   diff;
  logic              borrow;
  logic [2*XLEN-1:0] div_nx;
  logic [2*XLEN-1:0] step;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;
  logic [XLEN:0]     fin_spec;
  logic [XLEN-1:0]   fin_res;
`ifdef MULDIV_FASTPATH_EN
  logic [XLEN:0]     acc_spec;
  assign acc_spec = special(op, a, b);
`endif

  assign accept = start & ~abort & (state_q != CALC);

  assign sa_in  = a[XLEN-1] & ~(op[0] & (op[1] | op[2]));
  assign sb_in  = b[XLEN-1] & ~((~op[2] & op[1]) | (op[2] & op[0]));
  assign neg_in = (op[2] & op[1]) ? sa_in : (sa_in ^ sb_in);
  assign abs_a  = sa_in ? -a : a;
  assign abs_b  = sb_in ? -b : b;

  assign sum    = {1'b0, p_q[2*XLEN-1:XLEN]}
                + ({(XLEN+1){p_q[0]}} & {1'b0, m_q});
  assign mul_nx = {sum, p_q[XLEN-1:1]};

  assign rs     = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
  assign borrow = rs < {1'b0, m_q};
  assign diff   = rs[XLEN-1:0] - m_q;
  assign div_nx = borrow
                ? {rs[XLEN-1:0], p_q[XLEN-2:0], 1'b0}
                : {diff, p_q[XLEN-2:0], 1'b1};

  assign step = op_q[2] ? div_nx : mul_nx;

  // Sign is applied only to the final iteration's magnitude
  assign prod     = neg_q ? -step : step;
  assign quo      = neg_q ? -step[XLEN-1:0] : step[XLEN-1:0];
  assign rem      = neg_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
  assign fin_spec = special(op_q, a_q, b_q);

  always_comb begin
    fin_res = '0;
    if (fin_spec[XLEN])
      fin_res = fin_spec[XLEN-1:0];
    else if (op_q[2])
      fin_res = op_q[1] ? rem : quo;
    else if (op_q[1:0] == 2'b00)
      fin_res = prod[XLEN-1:0];
    else
      fin_res = prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    p_d     = p_q;
    neg_d   = neg_q;
    res_d   = res_q;
    if (abort) begin
      state_d = IDLE;
    end else if (state_q == CALC) begin
      p_d   = step;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(XLEN - 1)) begin
        state_d = DONE;
        res_d   = fin_res;
      end
    end else if (accept) begin
      op_d    = op;
      a_d     = a;
      b_d     = b;
      neg_d   = neg_in;
      cnt_d   = '0;
      m_d     = op[2] ? abs_b : abs_a;
      p_d     = {{XLEN{1'b0}}, op[2] ? abs_a : abs_b};
      state_d = CALC;
`ifdef MULDIV_FASTPATH_EN
      if (acc_spec[XLEN]) begin
        state_d = DONE;
        res_d   = acc_spec[XLEN-1:0];
      end
`endif
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      p_q     <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      p_q     <= p_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
    end
  end

  assign busy   = (state_q == CALC);
  assign done   = (state_q == DONE);
  assign result = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized bench for muldiv_unit against an arithmetic reference model.
// Expected latencies follow MULDIV_FASTPATH_EN when it is defined.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort;
  logic [2:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        busy, done;
  logic [31:0] result;

  logic        start8, abort8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [7:0]  result8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op_i),
    .a(a_i), .b(b_i), .abort(abort),
    .busy(busy), .done(done), .result(result)
  );

  muldiv_unit #(.XLEN(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8),
    .a(a8), .b(b8), .abort(abort8),
    .busy(busy8), .done(done8), .result(result8)
  );

  function automatic logic [31:0] model(
    input logic [2:0] o, input logic [31:0] x, input logic [31:0] y
  );
    longint      sx, sy, ux, uy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    case (o)
      3'd0: begin p = 64'(sx * sy); return p[31:0]; end
      3'd1: begin p = 64'(sx * sy); return p[63:32]; end
      3'd2: begin p = 64'(sx * uy); return p[63:32]; end
      3'd3: begin p = {32'd0, x} * {32'd0, y}; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        return 32'(sx / sy);
      end
      3'd5: begin
        if (y == 0) return 32'hFFFF_FFFF;
        return 32'(ux / uy);
      end
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sx % sy);
      end
      default: begin
        if (y == 0) return x;
        return 32'(ux % uy);
      end
    endcase
  endfunction

  function automatic int exp_lat(
    input logic [2:0] o, input logic [31:0] x, input logic [31:0] y
  );
    bit sp;
    if (o[2])
      sp = (y == 0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
    else
      sp = (x == 0) || (y == 0);
`ifdef MULDIV_FASTPATH_EN
    return sp ? 1 : 33;
`else
    return sp ? 33 : 33;
`endif
  endfunction

  // Issue one request; lat is the cycle (acceptance cycle = 1) showing done, -1 on timeout
  task automatic run_op(
    input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
    output logic [31:0] r, output int lat
  );
    op_i = o; a_i = x; b_i = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result;
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    op_i = '0; a_i = '0; b_i = '0;
    start8 = 1'b0; abort8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tests++;
    if ({busy, done, result} !== 34'd0) begin
      fails++;
      $display("FAIL reset: busy=%b done=%b result=%h want 0 0 0", busy, done, result);
    end
    tests++;
    if ({busy8, done8, result8} !== 10'd0) begin
      fails++;
      $display("FAIL reset8: busy=%b done=%b result=%h want 0", busy8, done8, result8);
    end
  endtask

  task automatic test_directed();
    logic [2:0]  ops[8];
    logic [31:0] as[8], bs[8];
    logic [31:0] r, want;
    int          lat;
    ops = '{3'd0, 3'd3, 3'd4, 3'd6, 3'd5, 3'd4, 3'd7, 3'd5};
    as  = '{32'd7, 32'hFFFF_FFFF, -32'sd7, -32'sd7, 32'd100,
            32'h8000_0000, 32'd5, 32'd5};
    bs  = '{-32'sd3, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd7,
            32'hFFFF_FFFF, 32'd0, 32'd0};
    for (int i = 0; i < 8; i++) begin
      run_op(ops[i], as[i], bs[i], r, lat);
      want = model(ops[i], as[i], bs[i]);
      tests++;
      if (r !== want) begin
        fails++;
        $display("FAIL directed_%0d: result=%h want %h", i, r, want);
      end
      tests++;
      if (lat !== exp_lat(ops[i], as[i], bs[i])) begin
        fails++;
        $display("FAIL directed_lat_%0d: cycle=%0d want %0d", i, lat,
                 exp_lat(ops[i], as[i], bs[i]));
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] x, y, r, want;
    int          lat;
    for (int i = 0; i < 48; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: x = 32'd0;
        3: y = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op(o, x, y, r, lat);
      want = model(o, x, y);
      tests++;
      if (r !== want || lat !== exp_lat(o, x, y)) begin
        fails++;
        $display("FAIL random_%0d op=%0d a=%h b=%h: result=%h cycle=%0d want %h cycle %0d",
                 i, o, x, y, r, lat, want, exp_lat(o, x, y));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ops[6];
    logic [31:0] as[6], bs[6];
    logic [31:0] want;
    int          k, cyc, guard;
    for (int i = 0; i < 6; i++) begin
      ops[i] = 3'($urandom_range(0, 7));
      as[i]  = $urandom | 32'd1;
      bs[i]  = ($urandom & 32'h7FFF_FFFF) | 32'd1;
    end
    op_i = ops[0]; a_i = as[0]; b_i = bs[0]; start = 1'b1;
    @(posedge clk); #1;
    k = 0; cyc = 1; guard = 0;
    while (k < 6 && guard < 400) begin
      if (done) begin
        want = model(ops[k], as[k], bs[k]);
        tests++;
        if (result !== want || cyc != 33) begin
          fails++;
          $display("FAIL b2b_%0d: result=%h cycle=%0d want %h cycle 33",
                   k, result, cyc, want);
        end
        k++;
        if (k < 6) begin
          op_i = ops[k]; a_i = as[k]; b_i = bs[k];
        end else begin
          start = 1'b0;
        end
        cyc = 0;
      end else if (cyc == 10) begin
        op_i = 3'($urandom_range(0, 7));
        a_i = $urandom;
        b_i = $urandom;
      end
      @(posedge clk); #1;
      cyc++;
      guard++;
    end
    start = 1'b0;
    tests++;
    if (k != 6) begin
      fails++;
      $display("FAIL b2b_timeout: completed=%0d want 6", k);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    logic [31:0] r;
    int          lat, seen;
    run_op(3'd5, 32'd100, 32'd7, r, lat);
    op_i = 3'd0; a_i = 32'd3; b_i = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd14) begin
      fails++;
      $display("FAIL abort: busy=%b done=%b result=%h want 0 0 0000000e",
               busy, done, result);
    end
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    tests++;
    if (seen != 0 || result !== 32'd14) begin
      fails++;
      $display("FAIL abort_nodone: pulses=%0d result=%h want 0 0000000e", seen, result);
    end
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_wins: busy=%b want 0", busy);
    end
  endtask

  task automatic test_rst_mid();
    op_i = 3'd1; a_i = 32'h1234_5678; b_i = 32'h0BAD_F00D; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_busy: busy=%b want 1", busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++;
    if ({busy, done, result} !== 34'd0) begin
      fails++;
      $display("FAIL rst_mid: busy=%b done=%b result=%h want 0 0 0", busy, done, result);
    end
  endtask

  task automatic test_xlen8();
    int lat;
    op8 = 3'd2; a8 = 8'h80; b8 = 8'hFF; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    tests++;
    if (!done8 || result8 !== 8'h80 || lat != 9) begin
      fails++;
      $display("FAIL xlen8_mulhsu: result=%h cycle=%0d want 80 cycle 9", result8, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_abort();
    test_rst_mid();
    test_xlen8();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
